// File: rtl/key_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_conditioner_pkg
//   Shared types and width helpers for the key_conditioner pushbutton front end.
//   - rep_state_t : auto-repeat FSM states (IDLE, DELAY, REPEAT)
//   - clog2_min1  : $clog2 clamped to at least one bit
//   - cnt_width   : bits needed to hold the values 0..max_count
//   - max2        : larger of two unsigned values
// -----------------------------------------------------------------------------
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return clog2_min1(max_count + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// -----------------------------------------------------------------------------
// key_channel
//   One pushbutton channel: two-flop synchroniser, optional inversion,
//   tick-based debounce, registered press/release pulses and a hold-to-repeat
//   auto-strobe FSM.
//
//   Ports
//     clk, rst_n  : clock, asynchronous active-low reset
//     key_raw_i   : raw asynchronous key input
//     tick_i      : shared one-cycle tick from the top level
//     level_o     : debounced active-high level
//     press_o     : one-cycle pulse after a debounced 0->1 transition
//     release_o   : one-cycle pulse after a debounced 1->0 transition
//     strobe_o    : press_o OR auto-repeat pulse
// -----------------------------------------------------------------------------
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter bit          ACTIVE_LOW          = 1'b1,
  parameter int unsigned DEBOUNCE_TICKS      = 5,
  parameter int unsigned REPEAT_DELAY_TICKS  = 500,
  parameter int unsigned REPEAT_PERIOD_TICKS = 100,
  parameter bit          REPEAT_EN           = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic strobe_o
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_TICKS);
  localparam int unsigned RP_W = clog2_min1(max2(REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS));

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD_TICKS - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            w_key;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_level;
  logic            r_level_q;
  logic            r_press;
  logic            r_release;
  logic            w_rise;
  logic            w_fall;
  rep_state_t      r_state;
  logic [RP_W-1:0] r_rp_cnt;
  logic            r_rep_pulse;

  // Sync flops reset to the idle raw level so leaving reset never looks like
  // a press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= key_raw_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key = r_sync2 ^ ACTIVE_LOW;

  // Debounce: any agreement clears the count immediately; disagreement has to
  // persist for DEBOUNCE_TICKS consecutive ticks before the level flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (w_key == r_level) begin
      r_db_cnt <= '0;
    end else if (tick_i) begin
      if (r_db_cnt == DB_LAST) begin
        r_level  <= ~r_level;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_rise = r_level & ~r_level_q;
  assign w_fall = ~r_level & r_level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  // Repeat FSM reacts to the same edge conditions that load press/release, so
  // it leaves IDLE on the cycle press_o is seen and returns to IDLE on the
  // cycle release_o is seen; a repeat due on that edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rp_cnt    <= '0;
      r_rep_pulse <= 1'b0;
    end else begin
      r_rep_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise && REPEAT_EN) begin
            r_state  <= DELAY;
            r_rp_cnt <= '0;
          end
        end
        DELAY: begin
          if (w_fall) begin
            r_state <= IDLE;
          end else if (tick_i) begin
            if (r_rp_cnt == DELAY_LAST) begin
              r_state     <= REPEAT;
              r_rp_cnt    <= '0;
              r_rep_pulse <= 1'b1;
            end else begin
              r_rp_cnt <= r_rp_cnt + RP_W'(1);
            end
          end
        end
        REPEAT: begin
          if (w_fall) begin
            r_state <= IDLE;
          end else if (tick_i) begin
            if (r_rp_cnt == PERIOD_LAST) begin
              r_rp_cnt    <= '0;
              r_rep_pulse <= 1'b1;
            end else begin
              r_rp_cnt <= r_rp_cnt + RP_W'(1);
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rp_cnt <= '0;
        end
      endcase
    end
  end

  assign level_o   = r_level;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign strobe_o  = r_press | r_rep_pulse;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   N-channel pushbutton front end: a shared tick generator driving N_CH
//   independent key_channel instances.
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     key_raw_i  : raw asynchronous key inputs [N_CH]
//     level_o    : debounced active-high levels [N_CH]
//     press_o    : one-cycle press pulses [N_CH]
//     release_o  : one-cycle release pulses [N_CH]
//     strobe_o   : press OR auto-repeat pulses [N_CH]
//     tick_o     : shared tick, one cycle every TICK_DIV clocks
// -----------------------------------------------------------------------------
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned     N_CH                = 4,
  parameter bit              ACTIVE_LOW          = 1'b1,
  parameter int unsigned     TICK_DIV            = 50000,
  parameter int unsigned     DEBOUNCE_TICKS      = 5,
  parameter int unsigned     REPEAT_DELAY_TICKS  = 500,
  parameter int unsigned     REPEAT_PERIOD_TICKS = 100,
  parameter logic [N_CH-1:0] REPEAT_EN           = {N_CH{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] key_raw_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] strobe_o,
  output logic            tick_o
);

  localparam int unsigned       TICK_W    = clog2_min1(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_tick;
  logic              w_tick_hit;

  assign w_tick_hit = (r_tick_cnt == TICK_LAST);

  // The tick is registered so it reads 0 in the first cycle after reset; with
  // TICK_DIV=1 it then stays high on every following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_hit ? '0 : r_tick_cnt + TICK_W'(1);
      r_tick     <= w_tick_hit;
    end
  end

  assign tick_o = r_tick;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW          (ACTIVE_LOW),
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .REPEAT_EN           (REPEAT_EN[ch])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw_i (key_raw_i[ch]),
      .tick_i    (r_tick),
      .level_o   (level_o[ch]),
      .press_o   (press_o[ch]),
      .release_o (release_o[ch]),
      .strobe_o  (strobe_o[ch])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//   Directed bench for key_conditioner with N_CH=2, ACTIVE_LOW=1, TICK_DIV=4,
//   DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_PERIOD_TICKS=2.
//   dut0 has repeat enabled on both channels, dut1 only on channel 0.
//   Cycle numbers below are relative to a cycle in which tick_o is seen high;
//   from there a key change shows on level_o 13 cycles later (2 sync + 3
//   ticks), press_o at +14, the first repeat at +33 and repeats every 8.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_raw;
  logic [1:0] w_level  [2];
  logic [1:0] w_press  [2];
  logic [1:0] w_rel    [2];
  logic [1:0] w_strobe [2];
  logic       w_tick   [2];

  int n_checks = 0;
  int n_errors = 0;

  int cyc;
  int cnt_tick;
  int bad_gap;
  int last_tick;
  int cnt_press  [2][2];
  int cnt_rel    [2][2];
  int cnt_strobe [2][2];
  int cnt_lvl_hi [2][2];
  int press_cyc1 [2];
  int rel_cyc0;
  int strobe_cyc0[$];
  int base;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_CH(2), .ACTIVE_LOW(1'b1), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
    .REPEAT_DELAY_TICKS(5), .REPEAT_PERIOD_TICKS(2), .REPEAT_EN(2'b11)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .key_raw_i(key_raw),
    .level_o(w_level[0]), .press_o(w_press[0]), .release_o(w_rel[0]),
    .strobe_o(w_strobe[0]), .tick_o(w_tick[0])
  );

  key_conditioner #(
    .N_CH(2), .ACTIVE_LOW(1'b1), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
    .REPEAT_DELAY_TICKS(5), .REPEAT_PERIOD_TICKS(2), .REPEAT_EN(2'b01)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .key_raw_i(key_raw),
    .level_o(w_level[1]), .press_o(w_press[1]), .release_o(w_rel[1]),
    .strobe_o(w_strobe[1]), .tick_o(w_tick[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_counts();
    cnt_tick  = 0;
    bad_gap   = 0;
    last_tick = -1;
    rel_cyc0  = -1;
    strobe_cyc0.delete();
    for (int d = 0; d < 2; d++) begin
      press_cyc1[d] = -1;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_press[d][ch]  = 0;
        cnt_rel[d][ch]    = 0;
        cnt_strobe[d][ch] = 0;
        cnt_lvl_hi[d][ch] = 0;
      end
    end
  endtask

  // Advance n cycles, sampling on the falling edge and accumulating activity.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (w_tick[0]) begin
        if (last_tick >= 0 && cyc - last_tick != 4) bad_gap++;
        last_tick = cyc;
        cnt_tick++;
      end
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 2; ch++) begin
          cnt_press[d][ch]  += int'(w_press[d][ch]);
          cnt_rel[d][ch]    += int'(w_rel[d][ch]);
          cnt_strobe[d][ch] += int'(w_strobe[d][ch]);
          cnt_lvl_hi[d][ch] += int'(w_level[d][ch]);
        end
      end
      if (w_strobe[0][0]) strobe_cyc0.push_back(cyc);
      if (w_rel[0][0] && rel_cyc0 < 0) rel_cyc0 = cyc;
      for (int ch = 0; ch < 2; ch++)
        if (w_press[1][ch] && press_cyc1[ch] < 0) press_cyc1[ch] = cyc;
    end
  endtask

  // Step until a cycle with tick_o high, bounded to two tick periods.
  task automatic align();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(1);
      found = w_tick[0];
    end
    check("align_tick", 32'(found), 32'd1);
  endtask

  function automatic int q_at(input int idx);
    return (idx < strobe_cyc0.size()) ? strobe_cyc0[idx] - base : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    rst_n   = 1'b0;
    key_raw = 2'b11;
    cyc     = 0;
    clear_counts();

    // 1. Reset and tick
    repeat (3) @(negedge clk);
    check("reset_outs_dut0", 32'({w_level[0], w_press[0], w_rel[0], w_strobe[0], w_tick[0]}), 32'd0);
    check("reset_outs_dut1", 32'({w_level[1], w_press[1], w_rel[1], w_strobe[1], w_tick[1]}), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    clear_counts();
    step(1);
    check("first_cycle_outs", 32'({w_level[0], w_press[0], w_rel[0], w_strobe[0], w_tick[0]}), 32'd0);
    step(199);
    check("t1_tick_count", 32'(cnt_tick), 32'd50);
    check("t1_tick_gap", 32'(bad_gap), 32'd0);
    bad = 0;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 2; ch++)
        bad += cnt_press[d][ch] + cnt_rel[d][ch] + cnt_strobe[d][ch] + cnt_lvl_hi[d][ch];
    check("t1_quiet", 32'(bad), 32'd0);

    // 2. Clean press on ch0, then 4. auto-repeat while held
    align();
    clear_counts();
    base    = cyc;
    key_raw = 2'b10;
    step(12);
    check("t2_level_early", 32'(w_level[0][0]), 32'd0);
    step(1);
    check("t2_level_rise", 32'(w_level[0][0]), 32'd1);
    check("t2_press_not_yet", 32'(w_press[0][0]), 32'd0);
    step(1);
    check("t2_press", 32'(w_press[0][0]), 32'd1);
    check("t2_strobe", 32'(w_strobe[0][0]), 32'd1);
    step(1);
    check("t2_press_one_cycle", 32'({w_press[0][0], w_strobe[0][0]}), 32'd0);
    step(57);
    key_raw = 2'b11;
    step(30);
    check("t2_press_count", 32'(cnt_press[0][0]), 32'd1);
    check("t2_ch1_quiet", 32'(cnt_press[0][1] + cnt_strobe[0][1] + cnt_lvl_hi[0][1] + cnt_rel[0][1]), 32'd0);
    check("t4_strobe_count", 32'(cnt_strobe[0][0]), 32'd8);
    check("t4_strobe0_cycle", 32'(q_at(0)), 32'd14);
    check("t4_first_repeat", 32'(q_at(1)), 32'd33);
    bad = 0;
    for (int i = 2; i < strobe_cyc0.size(); i++)
      if (strobe_cyc0[i] - strobe_cyc0[i-1] != 8) bad++;
    check("t4_repeat_period", 32'(bad), 32'd0);
    check("t4_last_repeat", 32'(q_at(7)), 32'd81);
    check("t4_release_cycle", 32'(rel_cyc0 - base), 32'd86);
    check("t4_release_count", 32'(cnt_rel[0][0]), 32'd1);
    check("t4_dut1_ch0_strobes", 32'(cnt_strobe[1][0]), 32'd8);

    // 3. Bounce rejection: 2 ticks low, 2 ticks high, ten times
    align();
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      key_raw = 2'b10;
      step(8);
      check("t3_db_cnt_mid", 32'(dut0.g_ch[0].u_ch.r_db_cnt), 32'd1);
      key_raw = 2'b11;
      step(8);
      check("t3_db_cnt_zero", 32'(dut0.g_ch[0].u_ch.r_db_cnt), 32'd0);
    end
    check("t3_no_activity", 32'(cnt_lvl_hi[0][0] + cnt_press[0][0] + cnt_strobe[0][0]), 32'd0);

    // 5. Both keys together; dut1 repeats only on ch0
    align();
    clear_counts();
    base    = cyc;
    key_raw = 2'b00;
    step(72);
    key_raw = 2'b11;
    step(30);
    check("t5_press_ch0_cycle", 32'(press_cyc1[0] - base), 32'd14);
    check("t5_press_ch1_cycle", 32'(press_cyc1[1] - base), 32'd14);
    check("t5_dut1_ch1_strobes", 32'(cnt_strobe[1][1]), 32'd1);
    check("t5_dut1_ch0_strobes", 32'(cnt_strobe[1][0]), 32'd8);
    check("t5_dut0_ch1_strobes", 32'(cnt_strobe[0][1]), 32'd8);
    check("t5_dut1_ch1_release", 32'(cnt_rel[1][1]), 32'd1);

    // 6. Asynchronous reset while ch0 is in REPEAT
    align();
    clear_counts();
    base    = cyc;
    key_raw = 2'b10;
    step(45);
    check("t6_state_repeat", 32'(dut0.g_ch[0].u_ch.r_state), 32'(REPEAT));
    #2;
    rst_n = 1'b0;
    #0.5;
    check("t6_outs_in_reset", 32'({w_level[0], w_press[0], w_rel[0], w_strobe[0], w_tick[0]}), 32'd0);
    check("t6_state_idle", 32'(dut0.g_ch[0].u_ch.r_state), 32'(IDLE));
    #0.5;
    rst_n = 1'b1;
    cyc   = 0;
    clear_counts();
    step(1);
    check("t6_first_cycle", 32'({w_level[0], w_press[0], w_strobe[0]}), 32'd0);
    step(11);
    check("t6_level_early", 32'(w_level[0][0]), 32'd0);
    step(1);
    check("t6_level_rise", 32'(w_level[0][0]), 32'd1);
    step(1);
    check("t6_press", 32'(w_press[0][0]), 32'd1);
    check("t6_strobe_count", 32'(cnt_strobe[0][0]), 32'd1);
    key_raw = 2'b11;
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
